// File: rtl/ps2_pkg.sv
// ps2_pkg: shared receiver state encoding and frame/entry constants.
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int PS2_ENTRY_W = 10;
endpackage

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: first-word-fall-through FIFO with explicit occupancy count.
// A pop is ignored while empty; a push is accepted while full only alongside a pop.
module ps2_sync_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign empty = cnt_q == '0;
    assign full = cnt_q == CW'(DEPTH);
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    always_comb begin
        mem_d = mem_q;
        wr_d = wr_q + DEPTH_LOG2'(do_push);
        rd_d = rd_q + DEPTH_LOG2'(do_pop);
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) mem_d[wr_q] = wdata;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver feeding a FWFT byte FIFO with sticky errors.
// Define PS2_RX_BREAK_DECODE_EN to fold E0/F0 prefixes into the ext/brk bits of the next entry.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3,
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  read_enable,
    input  logic                  err_clr,
    output logic [9:0]            data,
    output logic                  ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  parity_err,
    output logic                  frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [SYNC_STAGES-1:0] ck_q, ck_d, dt_q, dt_d;
    logic clk_s, data_s, prev_q, prev_d, strobe;
    ps2_state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shift_q, shift_d;
    logic par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic ovf_q, ovf_d, pe_q, pe_d, fe_q, fe_d;
    logic byte_ok, fe_evt, pe_evt, push, full, empty, drop;
    logic [PS2_ENTRY_W-1:0] wdata;
    assign clk_s = ck_q[SYNC_STAGES-1];
    assign data_s = dt_q[SYNC_STAGES-1];
    assign strobe = prev_q && !clk_s;
    always_comb begin
        ck_d = {ck_q[SYNC_STAGES-2:0], ps2_clk};
        dt_d = {dt_q[SYNC_STAGES-2:0], ps2_data};
        prev_d = clk_s;
        state_d = state_q;
        idx_d = idx_q;
        shift_d = shift_q;
        par_d = par_q;
        tmo_d = '0;
        byte_ok = 1'b0;
        fe_evt = 1'b0;
        pe_evt = 1'b0;
        if (state_q != IDLE) tmo_d = strobe ? '0 : tmo_q + 1'b1;
        if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            tmo_d = '0;
            fe_evt = 1'b1;
        end else if (strobe) begin
            case (state_q)
                IDLE: begin
                    fe_evt = data_s;
                    state_d = data_s ? IDLE : DATA;
                    idx_d = '0;
                end
                DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    idx_d = idx_q + 1'b1;
                    state_d = idx_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d = data_s;
                    state_d = STOP;
                end
                default: begin
                    state_d = IDLE;
                    fe_evt = !data_s;
                    pe_evt = !(^{shift_q, par_q});
                    byte_ok = data_s && (^{shift_q, par_q});
                end
            endcase
        end
    end
`ifdef PS2_RX_BREAK_DECODE_EN
    logic ext_q, ext_d, brk_q, brk_d;
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push = 1'b0;
        if (fe_evt || pe_evt) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == PS2_EXT_PREFIX) ext_d = 1'b1;
            else if (shift_q == PS2_BRK_PREFIX) brk_d = 1'b1;
            else begin
                push = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end
    assign wdata = {ext_q, brk_q, shift_q};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end
`else
    assign push = byte_ok;
    assign wdata = {2'b00, shift_q};
`endif
    // a byte is lost only when full and no pop can free a slot this cycle
    assign drop = push && full && !(read_enable && !empty);
    always_comb begin
        ovf_d = (ovf_q && !err_clr) || drop;
        pe_d = (pe_q && !err_clr) || pe_evt;
        fe_d = (fe_q && !err_clr) || fe_evt;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_q <= '1;
            dt_q <= '1;
            prev_q <= 1'b1;
            state_q <= IDLE;
            idx_q <= '0;
            shift_q <= '0;
            par_q <= 1'b0;
            tmo_q <= '0;
            ovf_q <= 1'b0;
            pe_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            ck_q <= ck_d;
            dt_q <= dt_d;
            prev_q <= prev_d;
            state_q <= state_d;
            idx_q <= idx_d;
            shift_q <= shift_d;
            par_q <= par_d;
            tmo_q <= tmo_d;
            ovf_q <= ovf_d;
            pe_q <= pe_d;
            fe_q <= fe_d;
        end
    end
    ps2_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(PS2_ENTRY_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(read_enable),
        .wdata(wdata),
        .rdata(data),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign ready = !empty;
    assign overflow = ovf_q;
    assign parity_err = pe_q;
    assign frame_err = fe_q;
endmodule
